// File: rtl/led_meter.sv
// Audio level bar-graph driver: clamps each sampled level, tracks a held and
// slowly decaying peak marker, and renders BAR / DOT / BAR_PEAK / FREEZE views.
module led_meter #(
  parameter int N_BAR       = 9,
  parameter int LVL_W       = 4,
  parameter int HOLD_TICKS  = 8,
  parameter int DECAY_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [LVL_W-1:0] level,
  input  logic [1:0]       mode,
  input  logic             flag_in,
  output logic [15:0]      led
);

  localparam logic [1:0] M_BAR      = 2'b00;
  localparam logic [1:0] M_DOT      = 2'b01;
  localparam logic [1:0] M_BAR_PEAK = 2'b10;
  localparam logic [1:0] M_FREEZE   = 2'b11;

  localparam logic [LVL_W-1:0] N_BAR_L = LVL_W'(N_BAR);
  localparam logic [7:0]       HOLD_L  = 8'(HOLD_TICKS);
  localparam logic [7:0]       DECAY_L = 8'(DECAY_TICKS);

  logic [LVL_W-1:0] cur, pk, cur_n, pk_n, lvl_c, pk_dec;
  logic [7:0]       hc, dc, hc_n, dc_n;
  logic [14:0]      disp;
  logic             upd;
  int               cur_i, pk_i;

  // tick is a one-cycle strobe with no backpressure: level is taken on every
  // cycle where tick=1 and mode is not FREEZE; there is no ready/acknowledge.
  assign upd    = tick && (mode != M_FREEZE);
  assign lvl_c  = (level > N_BAR_L) ? N_BAR_L : level;
  assign pk_dec = pk - LVL_W'(1);

  always_comb begin
    cur_n = cur;
    pk_n  = pk;
    hc_n  = hc;
    dc_n  = dc;
    if (upd) begin
      cur_n = lvl_c;
      if (lvl_c >= pk) begin
        pk_n = lvl_c;
        hc_n = HOLD_L;
        dc_n = DECAY_L;
      end else if (hc != 8'd0) begin
        hc_n = hc - 8'd1;
      end else if (dc > 8'd1) begin
        dc_n = dc - 8'd1;
      end else begin
        // Peak is strictly above lvl_c here, so this floor only guards the invariant.
        pk_n = (pk_dec < lvl_c) ? lvl_c : pk_dec;
        dc_n = DECAY_L;
      end
    end
  end

  // Display is built from the registered state, giving tick->led latency of two edges.
  always_comb begin
    disp  = '0;
    cur_i = int'(cur);
    pk_i  = int'(pk);
    for (int i = 0; i < 15; i++) begin
      if (i < N_BAR) begin
        case (mode)
          M_BAR:      disp[i] = (i < cur_i);
          M_DOT:      disp[i] = (cur_i != 0) && (i == cur_i - 1);
          M_BAR_PEAK: disp[i] = (i < cur_i) || ((pk_i != 0) && (i == pk_i - 1));
          default:    disp[i] = led[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= '0;
      pk  <= '0;
      hc  <= '0;
      dc  <= '0;
      led <= 16'h0000;
    end else begin
      cur       <= cur_n;
      pk        <= pk_n;
      hc        <= hc_n;
      dc        <= dc_n;
      led[14:0] <= disp;
      led[15]   <= flag_in;
    end
  end

endmodule

// File: tb/tb_led_meter.sv
// Scoreboard bench for led_meter: a tick-counting peak model predicts led for
// every clock edge; a monitor pops and compares, directed steps check literals.
module tb_led_meter;

  localparam int N_BAR = 9;
  localparam int HOLD  = 8;
  localparam int DECAY = 2;

  localparam logic [1:0] BAR      = 2'b00;
  localparam logic [1:0] DOT      = 2'b01;
  localparam logic [1:0] BAR_PEAK = 2'b10;
  localparam logic [1:0] FREEZE   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  level = 4'd0;
  logic [1:0]  mode = BAR;
  logic        flag_in = 1'b0;
  logic [15:0] led;

  logic [15:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // model state: displayed level, peak, ticks left until the next peak step
  int m_cur = 0;
  int m_pk = 0;
  int m_wait = 0;
  logic [15:0] m_led = 16'h0000;

  led_meter #(.N_BAR(N_BAR), .LVL_W(4), .HOLD_TICKS(HOLD), .DECAY_TICKS(DECAY)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .level(level),
    .mode(mode), .flag_in(flag_in), .led(led)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] view(input logic [1:0] md, input int c, input int p);
    int v;
    case (md)
      BAR:      v = (1 << c) - 1;
      DOT:      v = (c == 0) ? 0 : (1 << (c - 1));
      BAR_PEAK: v = ((1 << c) - 1) | ((p == 0) ? 0 : (1 << (p - 1)));
      default:  v = 0;
    endcase
    return v[14:0];
  endfunction

  // expected led after the edge that samples these inputs
  task automatic model_edge(input logic r, input logic t, input int lv,
                            input logic [1:0] md, input logic fl);
    int lc;
    if (!r) begin
      m_cur = 0; m_pk = 0; m_wait = 0; m_led = 16'h0000;
    end else begin
      if (md != FREEZE) m_led[14:0] = view(md, m_cur, m_pk);
      m_led[15] = fl;
      if (t && md != FREEZE) begin
        lc = (lv > N_BAR) ? N_BAR : lv;
        m_cur = lc;
        if (lc >= m_pk) begin
          m_pk = lc;
          m_wait = HOLD + DECAY;
        end else begin
          m_wait = m_wait - 1;
          if (m_wait == 0) begin
            m_pk = m_pk - 1;
            m_wait = DECAY;
          end
          if (m_pk < lc) m_pk = lc;
        end
      end
    end
    exp_q.push_back(m_led);
  endtask

  // driver: apply inputs for one edge, record expectation, return 1 time unit after it
  task automatic step(input logic r, input logic t, input logic [3:0] lv,
                      input logic [1:0] md, input logic fl);
    rst_n = r; tick = t; level = lv; mode = md; flag_in = fl;
    @(posedge clk);
    model_edge(r, t, int'(lv), md, fl);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (led !== e) begin
          fails++;
          $display("FAIL sb_led at %0t: got %h expected %h", $time, led, e);
        end
      end
    end
  end

  initial begin
    logic r, t, fl;
    logic [3:0] lv;
    logic [1:0] md;

    repeat (3) step(1'b0, 1'b0, 4'd0, BAR, 1'b0);
    check("reset_led", led, 16'h0000);

    // level 5 in BAR, then level 0
    step(1'b1, 1'b1, 4'd5, BAR, 1'b0);
    step(1'b1, 1'b0, 4'd0, BAR, 1'b0);
    check("bar_5", led, 16'h001F);
    step(1'b1, 1'b1, 4'd0, BAR, 1'b0);
    step(1'b1, 1'b0, 4'd0, BAR, 1'b0);
    check("bar_0", led, 16'h0000);

    // back-to-back ticks step the bar on consecutive cycles
    step(1'b1, 1'b1, 4'd1, BAR, 1'b0);
    step(1'b1, 1'b1, 4'd2, BAR, 1'b0);
    check("b2b_1", led, 16'h0001);
    step(1'b1, 1'b1, 4'd3, BAR, 1'b0);
    check("b2b_2", led, 16'h0003);
    step(1'b1, 1'b0, 4'd0, BAR, 1'b0);
    check("b2b_3", led, 16'h0007);

    // DOT saturates at the top LED
    step(1'b1, 1'b1, 4'd15, DOT, 1'b0);
    step(1'b1, 1'b0, 4'd0, DOT, 1'b0);
    check("dot_sat", led, 16'h0100);
    step(1'b1, 1'b1, 4'd0, DOT, 1'b0);
    step(1'b1, 1'b0, 4'd0, DOT, 1'b0);
    check("dot_0", led, 16'h0000);

    // peak hold then decay down to the bar
    step(1'b1, 1'b1, 4'd9, BAR_PEAK, 1'b0);
    step(1'b1, 1'b1, 4'd2, BAR_PEAK, 1'b0);
    check("peak_full", led, 16'h01FF);
    step(1'b1, 1'b1, 4'd2, BAR_PEAK, 1'b0);
    check("peak_hold", led, 16'h0103);
    repeat (40) step(1'b1, 1'b1, 4'd2, BAR_PEAK, 1'b0);
    step(1'b1, 1'b0, 4'd0, BAR_PEAK, 1'b0);
    check("peak_settled", led, 16'h0003);

    // FREEZE holds the bar and ignores ticks; flag still passes through
    step(1'b1, 1'b1, 4'd4, BAR, 1'b0);
    step(1'b1, 1'b0, 4'd0, BAR, 1'b0);
    check("pre_freeze", led, 16'h000F);
    step(1'b1, 1'b1, 4'd9, FREEZE, 1'b1);
    check("freeze_flag", led, 16'h800F);
    repeat (3) step(1'b1, 1'b1, 4'd9, FREEZE, 1'b1);
    check("freeze_hold", led, 16'h800F);
    step(1'b1, 1'b0, 4'd0, BAR, 1'b0);
    check("unfreeze", led, 16'h000F);

    // reset mid-hold with a coincident tick
    step(1'b1, 1'b1, 4'd7, BAR_PEAK, 1'b0);
    step(1'b1, 1'b1, 4'd2, BAR_PEAK, 1'b0);
    step(1'b1, 1'b0, 4'd0, BAR_PEAK, 1'b0);
    check("mid_hold", led, 16'h0043);
    step(1'b0, 1'b1, 4'd9, BAR_PEAK, 1'b1);
    check("reset_tick", led, 16'h0000);
    step(1'b1, 1'b1, 4'd3, BAR_PEAK, 1'b0);
    step(1'b1, 1'b0, 4'd0, BAR_PEAK, 1'b0);
    check("post_reset", led, 16'h0007);

    // randomized traffic, mode changes held for several cycles
    md = BAR;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) != 0);
      t  = ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) md = 2'($urandom_range(0, 3));
      fl = 1'($urandom_range(0, 1));
      step(r, t, lv, md, fl);
    end

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
